// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types and defaults.
// Provides the mul/div FSM state enum, the hard-wired zero register index
// and the default multiply/divide latencies.
package cpu_pkg;
    typedef enum logic {IDLE, BUSY} md_state_t;
    localparam logic [4:0] REG_ZERO    = 5'd0;
    localparam int         MUL_LAT_DEF = 4;
    localparam int         DIV_LAT_DEF = 32;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage hazard bus.
// master: drives ID/EX/MEM control fields, receives pipeline enables,
//         flush/bubble, mul/div status and the stall counter.
// slave:  the hazard controller side.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
    logic [4:0]       id_rs, id_rt, ex_dst, mem_dst;
    logic             id_use_rs, id_use_rt, id_is_branch, id_branch_taken;
    logic             id_md_start, id_md_is_div, id_reads_hilo;
    logic             ex_mem_read, ex_reg_write, mem_mem_read;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done;
    logic [CNT_W-1:0] stall_cycles;
    modport master (
        output id_rs, id_rt, ex_dst, mem_dst, id_use_rs, id_use_rt, id_is_branch,
               id_branch_taken, id_md_start, id_md_is_div, id_reads_hilo,
               ex_mem_read, ex_reg_write, mem_mem_read,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done, stall_cycles
    );
    modport slave (
        input  id_rs, id_rt, ex_dst, mem_dst, id_use_rs, id_use_rt, id_is_branch,
               id_branch_taken, id_md_start, id_md_is_div, id_reads_hilo,
               ex_mem_read, ex_reg_write, mem_mem_read,
        output pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done, stall_cycles
    );
endinterface

// File: rtl/hazard_match.sv
// hazard_match: source/destination register comparator.
// i_src/i_use: source register and its read flag; i_dst/i_wr: destination
// and its qualifying write flag; o_hit: dependency found ($0 never matches).
module hazard_match
    import cpu_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_use,
    input  logic [4:0] i_dst,
    input  logic       i_wr,
    output logic       o_hit
);
    assign o_hit = i_wr && i_use && (i_src != REG_ZERO) && (i_src == i_dst);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard controller of the 5-stage pipeline.
// clk/reset: clock and synchronous active-high reset.
// bus: slave side of hazard_ctrl_if (ID/EX/MEM control fields in; PC and
//      IF/ID enables, IF/ID flush, ID/EX bubble, mul/div status and the
//      saturating stall-cycle counter out).
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 32
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave bus
);
    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    md_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [5:0][4:0]  w_src, w_dst;
    logic [5:0]       w_use, w_wr, w_hit;
    logic             w_load_use, w_br_hz, w_md_hz, w_stall, w_start, w_busy;

    // Bits 1:0 load-use vs EX, 3:2 branch vs EX ALU write, 5:4 branch vs MEM load.
    assign w_src = {bus.id_rt, bus.id_rs, bus.id_rt, bus.id_rs, bus.id_rt, bus.id_rs};
    assign w_use = {bus.id_use_rt, bus.id_use_rs, bus.id_use_rt, bus.id_use_rs, bus.id_use_rt, bus.id_use_rs};
    assign w_dst = {bus.mem_dst, bus.mem_dst, bus.ex_dst, bus.ex_dst, bus.ex_dst, bus.ex_dst};
    assign w_wr  = {{2{bus.mem_mem_read}}, {2{bus.ex_reg_write}}, {2{bus.ex_mem_read}}};

    for (genvar i = 0; i < 6; i++) begin : g_match
        hazard_match u_match (
            .i_src (w_src[i]),
            .i_use (w_use[i]),
            .i_dst (w_dst[i]),
            .i_wr  (w_wr[i]),
            .o_hit (w_hit[i])
        );
    end

    assign w_busy     = (r_state == BUSY);
    assign w_load_use = |w_hit[1:0];
    assign w_br_hz    = bus.id_is_branch && (|w_hit[5:2]);
    assign w_md_hz    = w_busy && (bus.id_reads_hilo || bus.id_md_start);
    assign w_stall    = w_load_use || w_br_hz || w_md_hz;
    assign w_start    = !w_stall && bus.id_md_start;

    assign bus.pc_write     = !w_stall;
    assign bus.ifid_write   = !w_stall;
    assign bus.idex_bubble  = w_stall;
    assign bus.ifid_flush   = !w_stall && bus.id_is_branch && bus.id_branch_taken;
    assign bus.md_busy      = w_busy;
    assign bus.md_done      = w_busy && (r_cnt == '0);
    assign bus.stall_cycles = r_stall_cycles;

    // cnt holds remaining busy cycles minus one, so done fires when it hits 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (r_state == IDLE) begin
            if (w_start) begin
                r_state <= BUSY;
                r_cnt   <= bus.id_md_is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
            end
        end else begin
            r_state <= (r_cnt == '0) ? IDLE : BUSY;
            r_cnt   <= (r_cnt == '0) ? '0 : r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cycles <= '0;
        else if (w_stall && !(&r_stall_cycles))
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl.
module tb_hazard_ctrl;
    typedef struct packed {
        logic        pcw, ifw, fl, bub, bsy, dn;
        logic [31:0] sc;
    } obs_t;
    typedef struct {
        string name;
        obs_t  v;
    } item_t;

    logic  clk = 0, reset = 1;
    item_t q[$];
    int    checks = 0, errors = 0;

    hazard_ctrl_if #(.CNT_W(32)) bus ();
    hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic clr();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
        bus.id_is_branch = 0; bus.id_branch_taken = 0; bus.id_md_start = 0;
        bus.id_md_is_div = 0; bus.id_reads_hilo = 0; bus.ex_mem_read = 0;
        bus.ex_reg_write = 0; bus.ex_dst = 0; bus.mem_mem_read = 0; bus.mem_dst = 0;
    endtask

    // Push the expectation for the cycle whose inputs are currently applied, then advance.
    task automatic exp_cyc(input string name, input logic pcw, ifw, fl, bub, bsy, dn, input int sc);
        item_t it;
        it.name = name;
        it.v = '{pcw, ifw, fl, bub, bsy, dn, 32'(sc)};
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            obs_t  a;
            it = q.pop_front();
            a = '{bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_bubble,
                  bus.md_busy, bus.md_done, bus.stall_cycles};
            checks++;
            if (a !== it.v) begin
                errors++;
                $display("FAIL %s got pcw=%b ifw=%b fl=%b bub=%b busy=%b done=%b sc=%0d expected pcw=%b ifw=%b fl=%b bub=%b busy=%b done=%b sc=%0d",
                         it.name, a.pcw, a.ifw, a.fl, a.bub, a.bsy, a.dn, a.sc,
                         it.v.pcw, it.v.ifw, it.v.fl, it.v.bub, it.v.bsy, it.v.dn, it.v.sc);
            end
        end
    end

    initial begin
        clr();
        repeat (2) @(posedge clk);
        #1;
        exp_cyc("reset", 1, 1, 0, 0, 0, 0, 0);
        reset = 0;
        // load-use on rs
        bus.ex_mem_read = 1; bus.ex_dst = 8; bus.id_rs = 8; bus.id_use_rs = 1;
        exp_cyc("lu_rs_stall", 0, 0, 0, 1, 0, 0, 0);
        bus.ex_mem_read = 0; bus.ex_dst = 3; bus.mem_mem_read = 1; bus.mem_dst = 8;
        exp_cyc("lu_rs_release", 1, 1, 0, 0, 0, 0, 1);
        // load-use on rt
        clr(); bus.ex_mem_read = 1; bus.ex_dst = 8; bus.id_rt = 8; bus.id_use_rt = 1;
        exp_cyc("lu_rt_stall", 0, 0, 0, 1, 0, 0, 1);
        clr();
        exp_cyc("lu_rt_release", 1, 1, 0, 0, 0, 0, 2);
        // register 0 and unused source never match
        bus.ex_mem_read = 1; bus.ex_dst = 0; bus.id_rs = 0; bus.id_use_rs = 1;
        exp_cyc("lu_reg0", 1, 1, 0, 0, 0, 0, 2);
        bus.ex_dst = 8; bus.id_rs = 8; bus.id_use_rs = 0;
        exp_cyc("lu_nouse", 1, 1, 0, 0, 0, 0, 2);
        // branch after ALU op: 1 stall, taken flush suppressed while stalled
        clr(); bus.id_is_branch = 1; bus.id_branch_taken = 1; bus.id_rs = 9; bus.id_use_rs = 1;
        bus.ex_reg_write = 1; bus.ex_dst = 9;
        exp_cyc("br_alu_stall", 0, 0, 0, 1, 0, 0, 2);
        bus.ex_reg_write = 0; bus.ex_dst = 0; bus.mem_dst = 9;
        exp_cyc("br_alu_flush", 1, 1, 1, 0, 0, 0, 3);
        clr();
        exp_cyc("br_alu_after", 1, 1, 0, 0, 0, 0, 3);
        // branch after load: 2 stalls, then taken flush for one cycle
        bus.id_is_branch = 1; bus.id_rt = 9; bus.id_use_rt = 1;
        bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_dst = 9;
        exp_cyc("br_lw_stall1", 0, 0, 0, 1, 0, 0, 3);
        bus.ex_mem_read = 0; bus.ex_reg_write = 0; bus.ex_dst = 0;
        bus.mem_mem_read = 1; bus.mem_dst = 9;
        exp_cyc("br_lw_stall2", 0, 0, 0, 1, 0, 0, 4);
        bus.mem_mem_read = 0; bus.mem_dst = 0; bus.id_branch_taken = 1;
        exp_cyc("br_lw_flush", 1, 1, 1, 0, 0, 0, 5);
        clr();
        exp_cyc("br_lw_after", 1, 1, 0, 0, 0, 0, 5);
        // div then mflo: 32 busy cycles, mflo stalled through md_done
        bus.id_md_start = 1; bus.id_md_is_div = 1;
        exp_cyc("div_start", 1, 1, 0, 0, 0, 0, 5);
        clr(); bus.id_reads_hilo = 1;
        for (int k = 1; k <= 32; k++)
            exp_cyc($sformatf("div_busy%0d", k), 0, 0, 0, 1, 1, (k == 32), 4 + k);
        exp_cyc("div_mflo_go", 1, 1, 0, 0, 0, 0, 37);
        // mult then independent ops: no stall, 4 busy cycles
        clr(); bus.id_md_start = 1;
        exp_cyc("mul_start", 1, 1, 0, 0, 0, 0, 37);
        clr(); bus.id_rs = 4; bus.id_use_rs = 1;
        for (int k = 1; k <= 4; k++)
            exp_cyc($sformatf("mul_busy%0d", k), 1, 1, 0, 0, 1, (k == 4), 37);
        // back-to-back mult in the first idle cycle is accepted without stall
        clr(); bus.id_md_start = 1;
        exp_cyc("mul_b2b", 1, 1, 0, 0, 0, 0, 37);
        clr();
        exp_cyc("mul2_busy1", 1, 1, 0, 0, 1, 0, 37);
        bus.id_md_start = 1;
        exp_cyc("mul2_start_blocked", 0, 0, 0, 1, 1, 0, 37);
        clr();
        exp_cyc("mul2_busy3", 1, 1, 0, 0, 1, 0, 38);
        exp_cyc("mul2_busy4", 1, 1, 0, 0, 1, 1, 38);
        exp_cyc("mul2_idle", 1, 1, 0, 0, 0, 0, 38);
        // reset in busy cycle 10 of a div aborts with no done pulse
        bus.id_md_start = 1; bus.id_md_is_div = 1;
        exp_cyc("div2_start", 1, 1, 0, 0, 0, 0, 38);
        clr();
        for (int k = 1; k <= 9; k++)
            exp_cyc($sformatf("div2_busy%0d", k), 1, 1, 0, 0, 1, 0, 38);
        reset = 1;
        exp_cyc("div2_reset_cycle", 1, 1, 0, 0, 1, 0, 38);
        reset = 0;
        exp_cyc("div2_after_reset", 1, 1, 0, 0, 0, 0, 0);
        exp_cyc("div2_still_idle", 1, 1, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
